network_interface: RTL and testbench
====================================

// Module: network_interface
// PURPOSE
//  Core-side endpoint of the router's core port (index 0). The TX path buffers packets from the local core and
//  injects them into the router under the valid/enable protocol. The RX path accepts packets ejected by the router,
//  buffers them for the core, and checks that each one is addressed to this node. One instance per mesh node.
// PARAMETERS
//  X_LOC     0   node X coordinate; compared against rx x_dest
//  Y_LOC     0   node Y coordinate; compared against rx y_dest
//  TX_DEPTH  4   TX queue depth in packets (power of 2, >=2)
//  RX_DEPTH  4   RX queue depth in packets (power of 2, >=2)
//  CNT_W     16  width of packet counters
// PORTS
//  clk            in   1        clock; all logic is on the rising edge
//  reset_n        in   1        reset: synchronous, active-low
//  i_tx_packet    in   packet_t packet from core
//  i_tx_val       in   1        i_tx_packet valid
//  o_tx_ready     out  1        TX queue can accept; core push = i_tx_val & o_tx_ready
//  o_data         out  packet_t to router core-port input
//  o_data_val     out  1        o_data valid
//  i_en           in   1        router input FIFO enable; router transfer = o_data_val & i_en
//  i_data         in   packet_t from router core-port output
//  i_data_val     in   1        i_data valid; accepted unconditionally (router only sends while o_en=1)
//  o_en           out  1        enable to router: RX queue has space
//  o_rx_packet    out  packet_t head of RX queue to core
//  o_rx_val       out  1        o_rx_packet valid
//  i_rx_ready     in   1        core pop = o_rx_val & i_rx_ready
//  o_tx_count     out  CNT_W    packets transferred into router, saturating
//  o_rx_count     out  CNT_W    packets accepted from router, saturating
//  o_misroute     out  1        sticky: a packet was received with (x_dest,y_dest) != (X_LOC,Y_LOC)
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge): both queues empty, output stage in state IDLE, o_data_val=0, o_data='0,
//   o_rx_val=0, counters=0, o_misroute=0. o_tx_ready=1 and o_en=1 from the first cycle after reset.
//   Reset asserted mid-transfer discards all queued and in-flight packets; no partial state survives.
//  TX queue: circular buffer with wrap-around pointers and a count of 0..TX_DEPTH. o_tx_ready = (count != TX_DEPTH),
//   combinational from registered count. A push while full cannot occur because ready=0.
//  TX output stage, registered FSM:
//   IDLE : o_data_val=0. If the queue is non-empty, load the head into the o_data register, pop, go to SEND.
//   SEND : o_data_val=1, o_data held stable until transfer. On o_data_val & i_en:
//          queue non-empty -> load next head, pop, stay in SEND (back-to-back, one packet per cycle);
//          otherwise -> IDLE.
//   Latency from core push into an empty NI with i_en=1 to router transfer is 2 cycles
//   (queue write, stage load, transfer edge). Push and pop in the same cycle are legal at any count; count unchanged.
//  RX queue: o_en = (rx count != RX_DEPTH), combinational from registered count. This gives the router one
//   free slot per cycle it sees o_en=1. A write occurs on i_data_val. i_data_val with a full queue is a protocol
//   error: the packet is dropped and o_misroute is set. Simultaneous write and pop are legal when full (pop first)
//   or empty (write, with o_rx_val rising next cycle; no bypass). o_rx_val = rx count != 0, and
//   o_rx_packet = head entry.
//  Misroute check happens on each write: (i_data.x_dest != X_LOC) | (i_data.y_dest != Y_LOC) sets o_misroute.
//   The packet is still queued. o_misroute clears only on reset.
//  Counters: o_tx_count increments on each router transfer, o_rx_count on each i_data_val. Both saturate at
//   2^CNT_W-1 with no wrap.
// TESTING
//  T1 single: push 1 pkt dest (2,1) with i_en=1 -> o_data_val rises 2 cycles after push; one-cycle pulse;
//     o_tx_count=1.
//  T2 backpressure: i_en=0, push 5 pkts with TX_DEPTH=4 -> o_tx_ready=0 after 5th accepted (4 queued + 1 staged);
//     o_data stable; raise i_en -> 5 transfers on 5 consecutive cycles in push order; o_tx_count=5.
//  T3 RX fill: i_rx_ready=0, drive 4 pkts to (X_LOC,Y_LOC) -> o_en=0 after 4th; release ready -> 4 pops in order;
//     o_en returns 1 the cycle after first pop; o_misroute=0.
//  T4 misroute/overflow: rx pkt dest (X_LOC+1,Y_LOC) -> o_misroute=1 and stays 1. Separately, i_data_val with
//     a full queue -> packet dropped and o_misroute=1.
//  T5 simultaneous: full RX queue with pop and write in one cycle -> count stays 4; order preserved; no drop.
//  T6 reset mid-operation: reset_n=0 for 1 cycle with both queues half-full and SEND active -> next cycle
//     o_data_val=0, o_rx_val=0, counters=0, o_tx_ready=1, o_en=1; CNT_W=2 saturation: 5 transfers -> o_tx_count=3.

Source files
------------

// File: rtl/network_interface.sv
// -----------------------------------------------------------------------------
// network_interface
//  Core-side endpoint of a mesh router's core port (port 0).
//  TX path: packets from the local core are buffered in a circular queue and
//  presented to the router through a registered output stage under the
//  valid/enable protocol (transfer = o_data_val & i_en).
//  RX path: packets ejected by the router are buffered for the core; each
//  written packet's destination is checked against this node's coordinates.
//
//  Ports
//   clk, reset_n              clock (rising edge), synchronous active-low reset
//   i_tx_packet/i_tx_val      packet from core, valid
//   o_tx_ready                TX queue has space (push = i_tx_val & o_tx_ready)
//   o_data/o_data_val         packet to router core-port input, valid
//   i_en                      router input enable (transfer = o_data_val & i_en)
//   i_data/i_data_val         packet from router core-port output, valid
//   o_en                      RX queue has space (enable to router)
//   o_rx_packet/o_rx_val      head of RX queue to core, valid
//   i_rx_ready                core pop = o_rx_val & i_rx_ready
//   o_tx_count/o_rx_count     saturating packet counters
//   o_misroute                sticky: misaddressed packet or RX overflow seen
// -----------------------------------------------------------------------------
package ni_pkg;
  typedef struct packed {
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [15:0] payload;
  } packet_t;
endpackage

module network_interface
  import ni_pkg::*;
#(
  parameter int unsigned X_LOC    = 0,
  parameter int unsigned Y_LOC    = 0,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  packet_t          i_tx_packet,
  input  logic             i_tx_val,
  output logic             o_tx_ready,
  output packet_t          o_data,
  output logic             o_data_val,
  input  logic             i_en,
  input  packet_t          i_data,
  input  logic             i_data_val,
  output logic             o_en,
  output packet_t          o_rx_packet,
  output logic             o_rx_val,
  input  logic             i_rx_ready,
  output logic [CNT_W-1:0] o_tx_count,
  output logic [CNT_W-1:0] o_rx_count,
  output logic             o_misroute
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
  localparam logic [3:0] X_ID = 4'(X_LOC);
  localparam logic [3:0] Y_ID = 4'(Y_LOC);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  // ---------------------------------------------------------------------------
  // TX queue
  // ---------------------------------------------------------------------------
  packet_t          r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wr;
  logic [TX_AW-1:0] r_tx_rd;
  logic [TX_AW:0]   r_tx_cnt;

  logic    w_tx_push;
  logic    w_tx_pop;
  logic    w_tx_nempty;
  logic    w_xfer;
  packet_t w_tx_head;

  state_t  r_state;
  packet_t r_data;
  logic    r_data_val;

  assign o_tx_ready  = (r_tx_cnt != TX_FULL);
  assign w_tx_nempty = (r_tx_cnt != '0);
  assign w_tx_push   = i_tx_val & o_tx_ready;
  assign w_tx_head   = r_tx_mem[r_tx_rd];
  assign w_xfer      = r_data_val & i_en;
  // The stage takes a new head whenever it is empty or is emptying this cycle.
  assign w_tx_pop    = w_tx_nempty & ((r_state == IDLE) | i_en);

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= i_tx_packet;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX output stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_data_val <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tx_nempty) begin
            r_data     <= w_tx_head;
            r_data_val <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (i_en) begin
            if (w_tx_nempty) begin
              r_data <= w_tx_head;
            end else begin
              r_data_val <= 1'b0;
              r_state    <= IDLE;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_data_val <= 1'b0;
        end
      endcase
    end
  end

  assign o_data     = r_data;
  assign o_data_val = r_data_val;

  // ---------------------------------------------------------------------------
  // RX queue
  // ---------------------------------------------------------------------------
  packet_t          r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wr;
  logic [RX_AW-1:0] r_rx_rd;
  logic [RX_AW:0]   r_rx_cnt;

  logic w_rx_full;
  logic w_rx_pop;
  logic w_rx_wr;
  logic w_rx_drop;
  logic w_rx_wrong;

  assign w_rx_full   = (r_rx_cnt == RX_FULL);
  assign o_en        = ~w_rx_full;
  assign o_rx_val    = (r_rx_cnt != '0);
  assign o_rx_packet = r_rx_mem[r_rx_rd];
  assign w_rx_pop    = o_rx_val & i_rx_ready;
  // A pop in the same cycle frees the slot, so a write to a full queue only
  // overflows when the core is not popping.
  assign w_rx_wr     = i_data_val & (~w_rx_full | w_rx_pop);
  assign w_rx_drop   = i_data_val & w_rx_full & ~w_rx_pop;
  assign w_rx_wrong  = i_data_val & ((i_data.x_dest != X_ID) | (i_data.y_dest != Y_ID));

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_rx_mem[r_rx_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_wr)  r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_wr, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status: saturating counters and sticky misroute flag
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_tx_count;
  logic [CNT_W-1:0] r_rx_count;
  logic             r_misroute;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_count <= '0;
      r_rx_count <= '0;
      r_misroute <= 1'b0;
    end else begin
      if (w_xfer && (r_tx_count != '1))     r_tx_count <= r_tx_count + 1'b1;
      if (i_data_val && (r_rx_count != '1)) r_rx_count <= r_rx_count + 1'b1;
      if (w_rx_drop || w_rx_wrong)          r_misroute <= 1'b1;
    end
  end

  assign o_tx_count = r_tx_count;
  assign o_rx_count = r_rx_count;
  assign o_misroute = r_misroute;

endmodule

// File: tb/tb_network_interface.sv
// -----------------------------------------------------------------------------
// tb_network_interface
//  Self-checking bench for network_interface. A scoreboard holds packets the
//  core pushes (TX) and packets the router delivers (RX); a negedge monitor
//  pops and compares them as the DUT transfers/delivers. A table of RX
//  destinations drives the misroute checks; multi-cycle corner cases are
//  hand-written sequences. A second instance with CNT_W=2 covers saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_network_interface;
  import ni_pkg::*;

  localparam int unsigned XL = 2;
  localparam int unsigned YL = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  packet_t     i_tx_packet, o_data, i_data, o_rx_packet;
  logic        i_tx_val, o_tx_ready, o_data_val, i_en, i_data_val, o_en, o_rx_val, i_rx_ready;
  logic [15:0] o_tx_count, o_rx_count;
  logic        o_misroute;

  packet_t     s_tx_packet, s_o_data, s_data, s_rx_packet;
  logic        s_tx_val, s_tx_ready, s_data_val_o, s_en_i, s_data_val, s_en_o, s_rx_val, s_rx_ready;
  logic [1:0]  s_tx_count, s_rx_count;
  logic        s_misroute;

  always #5 clk = ~clk;

  network_interface #(.X_LOC(XL), .Y_LOC(YL), .TX_DEPTH(4), .RX_DEPTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .i_tx_packet(i_tx_packet), .i_tx_val(i_tx_val), .o_tx_ready(o_tx_ready),
    .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en),
    .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
    .o_rx_packet(o_rx_packet), .o_rx_val(o_rx_val), .i_rx_ready(i_rx_ready),
    .o_tx_count(o_tx_count), .o_rx_count(o_rx_count), .o_misroute(o_misroute)
  );

  network_interface #(.X_LOC(0), .Y_LOC(0), .TX_DEPTH(4), .RX_DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n),
    .i_tx_packet(s_tx_packet), .i_tx_val(s_tx_val), .o_tx_ready(s_tx_ready),
    .o_data(s_o_data), .o_data_val(s_data_val_o), .i_en(s_en_i),
    .i_data(s_data), .i_data_val(s_data_val), .o_en(s_en_o),
    .o_rx_packet(s_rx_packet), .o_rx_val(s_rx_val), .i_rx_ready(s_rx_ready),
    .o_tx_count(s_tx_count), .o_rx_count(s_rx_count), .o_misroute(s_misroute)
  );

  int vectors    = 0;
  int miscompares = 0;

  packet_t tx_q[$];
  packet_t rx_q[$];

  typedef struct {
    logic [3:0]  x;
    logic [3:0]  y;
    logic [15:0] payload;
    logic        exp_mis;
  } vec_t;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic packet_t mk(logic [3:0] x, logic [3:0] y, logic [15:0] p);
    packet_t t;
    t.x_dest  = x;
    t.y_dest  = y;
    t.payload = p;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: sample handshakes mid-cycle, ahead of the capturing edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (i_tx_val && o_tx_ready) tx_q.push_back(i_tx_packet);
      if (o_data_val && i_en) begin
        if (tx_q.size() == 0) check("tx_unexpected", 32'(o_data), 32'hFFFF_FFFF);
        else check("tx_data", 32'(o_data), 32'(tx_q.pop_front()));
      end
      if (o_rx_val && i_rx_ready) begin
        if (rx_q.size() == 0) check("rx_unexpected", 32'(o_rx_packet), 32'hFFFF_FFFF);
        else check("rx_data", 32'(o_rx_packet), 32'(rx_q.pop_front()));
      end
    end
  end

  task automatic do_reset(int cycles);
    reset_n = 1'b0;
    tx_q.delete();
    rx_q.delete();
    repeat (cycles) tick();
    reset_n = 1'b1;
  endtask

  // Drive one RX packet for one cycle; queue it in the scoreboard if it should be kept.
  task automatic rx_send(packet_t p, bit keep);
    i_data     = p;
    i_data_val = 1'b1;
    if (keep) rx_q.push_back(p);
    tick();
    i_data_val = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'(XL),     4'(YL),     16'h0A01, 1'b0};
    vecs[1] = '{4'(XL),     4'(YL),     16'h0A02, 1'b0};
    vecs[2] = '{4'(XL + 1), 4'(YL),     16'h0A03, 1'b1};
    vecs[3] = '{4'(XL),     4'(YL),     16'h0A04, 1'b1};
    vecs[4] = '{4'(XL),     4'(YL + 1), 16'h0A05, 1'b1};

    reset_n = 1'b0; i_tx_packet = '0; i_tx_val = 1'b0; i_en = 1'b1;
    i_data = '0; i_data_val = 1'b0; i_rx_ready = 1'b1;
    s_tx_packet = '0; s_tx_val = 1'b0; s_en_i = 1'b1;
    s_data = '0; s_data_val = 1'b0; s_rx_ready = 1'b1;
    do_reset(2);

    // Reset state
    check("rst_data_val", 32'(o_data_val), 0);
    check("rst_data",     32'(o_data), 0);
    check("rst_rx_val",   32'(o_rx_val), 0);
    check("rst_tx_ready", 32'(o_tx_ready), 1);
    check("rst_en",       32'(o_en), 1);
    check("rst_tx_count", 32'(o_tx_count), 0);
    check("rst_rx_count", 32'(o_rx_count), 0);
    check("rst_misroute", 32'(o_misroute), 0);

    // T1: single packet, two-cycle latency, one-cycle valid pulse
    i_tx_packet = mk(4'd2, 4'd1, 16'h1111); i_tx_val = 1'b1;
    tick(); i_tx_val = 1'b0;
    check("t1_val_c1", 32'(o_data_val), 0);
    tick();
    check("t1_val_c2", 32'(o_data_val), 1);
    tick();
    check("t1_val_c3", 32'(o_data_val), 0);
    check("t1_tx_count", 32'(o_tx_count), 1);

    // T2: backpressure, 4 queued + 1 staged, then 5 back-to-back transfers
    i_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_tx_packet = mk(4'd3, 4'd0, 16'h2000 + 16'(k)); i_tx_val = 1'b1;
      tick();
    end
    i_tx_val = 1'b0;
    check("t2_ready_full", 32'(o_tx_ready), 0);
    tick(); tick();
    check("t2_hold_val",  32'(o_data_val), 1);
    check("t2_hold_data", 32'(o_data), 32'(mk(4'd3, 4'd0, 16'h2000)));
    i_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("t2_b2b_val", 32'(o_data_val), 1);
      tick();
    end
    check("t2_idle_val", 32'(o_data_val), 0);
    check("t2_tx_count", 32'(o_tx_count), 6);
    check("t2_ready",    32'(o_tx_ready), 1);
    check("t2_sb_empty", 32'(tx_q.size()), 0);

    // T3: RX fill, o_en drop, ordered drain
    i_rx_ready = 1'b0;
    for (int k = 0; k < 4; k++) rx_send(mk(4'(XL), 4'(YL), 16'h3000 + 16'(k)), 1'b1);
    check("t3_en_full",  32'(o_en), 0);
    check("t3_rx_val",   32'(o_rx_val), 1);
    check("t3_rx_count", 32'(o_rx_count), 4);
    i_rx_ready = 1'b1;
    tick();
    check("t3_en_back", 32'(o_en), 1);
    repeat (3) tick();
    check("t3_drained", 32'(o_rx_val), 0);
    check("t3_mis",     32'(o_misroute), 0);

    // T5: full queue with simultaneous pop and write
    i_rx_ready = 1'b0;
    for (int k = 0; k < 4; k++) rx_send(mk(4'(XL), 4'(YL), 16'h5000 + 16'(k)), 1'b1);
    i_rx_ready = 1'b1;
    rx_send(mk(4'(XL), 4'(YL), 16'h5004), 1'b1);
    i_rx_ready = 1'b0;
    check("t5_still_full", 32'(o_en), 0);
    check("t5_rx_count",   32'(o_rx_count), 9);
    check("t5_no_drop",    32'(o_misroute), 0);
    i_rx_ready = 1'b1;
    repeat (4) tick();
    check("t5_drained", 32'(o_rx_val), 0);
    check("t5_sb_empty", 32'(rx_q.size()), 0);

    // T4a: table of destinations; misroute is sticky
    for (int i = 0; i < 5; i++) begin
      rx_send(mk(vecs[i].x, vecs[i].y, vecs[i].payload), 1'b1);
      tick();
      check("t4_table_mis", 32'(o_misroute), 32'(vecs[i].exp_mis));
    end
    tick();
    check("t4_table_drained", 32'(rx_q.size()), 0);

    // T4b: overflow drops the packet and flags misroute
    do_reset(1);
    i_rx_ready = 1'b0;
    for (int k = 0; k < 4; k++) rx_send(mk(4'(XL), 4'(YL), 16'h4000 + 16'(k)), 1'b1);
    check("t4_pre_mis", 32'(o_misroute), 0);
    rx_send(mk(4'(XL), 4'(YL), 16'h40FF), 1'b0);
    check("t4_ovf_mis",   32'(o_misroute), 1);
    check("t4_ovf_count", 32'(o_rx_count), 5);
    i_rx_ready = 1'b1;
    repeat (4) tick();
    check("t4_ovf_dropped", 32'(o_rx_val), 0);
    check("t4_ovf_sb",      32'(rx_q.size()), 0);
    check("t4_mis_sticky",  32'(o_misroute), 1);

    // T6: reset in the middle of traffic
    do_reset(1);
    i_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_tx_packet = mk(4'd1, 4'd1, 16'h6000 + 16'(k)); i_tx_val = 1'b1;
      tick();
    end
    i_tx_val = 1'b0;
    i_rx_ready = 1'b0;
    for (int k = 0; k < 2; k++) rx_send(mk(4'(XL), 4'(YL), 16'h6100 + 16'(k)), 1'b1);
    check("t6_send_active", 32'(o_data_val), 1);
    do_reset(1);
    check("t6_data_val", 32'(o_data_val), 0);
    check("t6_rx_val",   32'(o_rx_val), 0);
    check("t6_tx_count", 32'(o_tx_count), 0);
    check("t6_rx_count", 32'(o_rx_count), 0);
    check("t6_tx_ready", 32'(o_tx_ready), 1);
    check("t6_en",       32'(o_en), 1);
    i_en = 1'b1; i_rx_ready = 1'b1;
    repeat (3) tick();
    check("t6_no_leftover_tx", 32'(o_data_val), 0);
    check("t6_no_leftover_rx", 32'(o_rx_val), 0);

    // Saturation on the CNT_W=2 instance
    for (int k = 0; k < 5; k++) begin
      s_tx_packet = mk(4'd0, 4'd0, 16'h7000 + 16'(k)); s_tx_val = 1'b1;
      s_data = mk(4'd0, 4'd0, 16'h7100 + 16'(k)); s_data_val = 1'b1;
      tick();
    end
    s_tx_val = 1'b0; s_data_val = 1'b0;
    check("sat_tx_mid", 32'(s_tx_count), 3);
    repeat (4) tick();
    check("sat_tx_count", 32'(s_tx_count), 3);
    check("sat_rx_count", 32'(s_rx_count), 3);
    check("sat_mis",      32'(s_misroute), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
